// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   - state_t  : sequencing states (idle, processing bits, one-cycle done)
//   - MaxBits  : largest supported operand width
package sub_pkg;

    localparam int unsigned MaxBits = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full subtractor: computes x - y - bin.
// Ports:
//   x    in   minuend bit
//   y    in   subtrahend bit
//   bin  in   borrow in
//   d    out  difference bit
//   bout out  borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        // Borrow when y exceeds x, or when x == y and a borrow is already pending.
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^BITS, one bit per clock,
// LSB first, through a single full-subtractor cell.
// Parameters:
//   BITS        operand/result width, 2..32
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       request; sampled only while idle
//   a, b        operands, captured on the accepting edge
//   busy        high while bits are being processed
//   done        one-cycle pulse when diff/borrow_out are updated
//   diff        registered result
//   borrow_out  registered final borrow (a < b unsigned)
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] diff,
    output logic            borrow_out
);

    localparam int unsigned CntW = $clog2(BITS);
    localparam logic [CntW-1:0] LastBit = CntW'(BITS - 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] a_sr_q, a_sr_d;
    logic [BITS-1:0] b_sr_q, b_sr_d;
    // Holds the BITS-1 low difference bits; the final bit joins them on the last edge.
    logic [BITS-2:0] work_q, work_d;
    logic            brw_q, brw_d;
    logic [BITS-1:0] diff_q, diff_d;
    logic            bo_q, bo_d;

    logic            d_bit;
    logic            bout_bit;
    logic [BITS-1:0] work_cat;

    full_subtractor u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (brw_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // New bit enters at the MSB; on the last edge this is the complete result.
    assign work_cat = {d_bit, work_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        work_d  = work_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bo_d    = bo_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sr_d = {1'b0, a_sr_q[BITS-1:1]};
                b_sr_d = {1'b0, b_sr_q[BITS-1:1]};
                work_d = work_cat[BITS-1:1];
                brw_d  = bout_bit;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    diff_d  = work_cat;
                    bo_d    = bout_bit;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            work_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            work_q  <= work_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
        end
    end

    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor, BITS=8 and BITS=3 instances.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start3;
    logic [7:0] a8, b8, diff8;
    logic [2:0] a3, b3, diff3;
    logic       busy8, done8, bo8;
    logic       busy3, done3, bo3;

    always #5 clk = ~clk;

    serial_subtractor #(.BITS(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8)
    );

    serial_subtractor #(.BITS(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .start      (start3),
        .a          (a3),
        .b          (b3),
        .busy       (busy3),
        .done       (done3),
        .diff       (diff3),
        .borrow_out (bo3)
    );

    typedef struct {
        logic [7:0] diff;
        logic       bo;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event, expected none/other (cycle %0d)", name, cyc);
    endtask

    // Monitors: pop and compare whenever a DUT presents done.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                fail_now("unexpected_done8");
            end else begin
                e = q8.pop_front();
                check("diff8", 32'(diff8), 32'(e.diff));
                check("borrow8", 32'(bo8), 32'(e.bo));
                check("latency8", 32'(cyc), 32'(e.cyc));
                check("busy_with_done8", 32'(busy8), 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (!rst && done3) begin
            if (q3.size() == 0) begin
                fail_now("unexpected_done3");
            end else begin
                e = q3.pop_front();
                check("diff3", 32'(diff3), 32'(e.diff));
                check("borrow3", 32'(bo3), 32'(e.bo));
                check("latency3", 32'(cyc), 32'(e.cyc));
                check("busy_with_done3", 32'(busy3), 32'd0);
            end
        end
    end

    // One operation on the selected instance; returns on the negedge where done is seen.
    task automatic op(input int w, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb);
        exp_t e;
        int   t;
        @(negedge clk);
        e.diff = ed;
        e.bo   = eb;
        if (w == 8) begin
            a8 = a; b8 = b; start8 = 1'b1;
            e.cyc = cyc + 1 + 8;
            q8.push_back(e);
        end else begin
            a3 = a[2:0]; b3 = b[2:0]; start3 = 1'b1;
            e.cyc = cyc + 1 + 3;
            q3.push_back(e);
        end
        @(negedge clk);
        if (w == 8) start8 = 1'b0;
        else        start3 = 1'b0;
        t = 0;
        while (!((w == 8) ? done8 : done3) && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30) fail_now("done_timeout");
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         dcnt;
        int         t;
        logic [7:0] ra, rb;
        logic [2:0] sa, sb, sd;
        exp_t       e;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; a3 = '0; b3 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_diff8", 32'(diff8), 0);
        check("rst_borrow8", 32'(bo8), 0);
        check("rst_busy3", 32'(busy3), 0);
        check("rst_diff3", 32'(diff3), 0);
        rst = 1'b0;

        // Directed, hand-computed.
        op(8, 8'h5A, 8'h3C, 8'h1E, 1'b0);
        op(8, 8'h00, 8'h01, 8'hFF, 1'b1);
        op(8, 8'h80, 8'h80, 8'h00, 1'b0);

        // Extra start pulses sampled at E3 (RUN) and E9 (DONE) are ignored.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        e.diff = 8'h22; e.bo = 1'b0; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        dcnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            start8 = (k == 2 || k == 8);
            a8 = 8'hFF; b8 = 8'h00;
            check("busy_seq", 32'(busy8), 32'(k < 8));
            if (done8) dcnt++;
        end
        start8 = 1'b0;
        check("single_done", 32'(dcnt), 32'd1);

        // Abort with reset mid-RUN: outputs clear at once, no done.
        @(negedge clk);
        a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy8), 0);
        check("abort_done", 32'(done8), 0);
        check("abort_diff", 32'(diff8), 0);
        check("abort_borrow", 32'(bo8), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op(8, 8'hF0, 8'h0F, 8'hE1, 1'b0);

        // start held high, operands changing every cycle: accepts every 10 cycles.
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            a8 = ra; b8 = rb; start8 = 1'b1;
            if (j % 10 == 0) begin
                e.diff = ra - rb; e.bo = (ra < rb); e.cyc = cyc + 1 + 8;
                q8.push_back(e);
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        t = 0;
        while (q8.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("held_start_drained", 32'(q8.size()), 0);

        // Random sweep on both widths against the arithmetic reference.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    op(8, ra, rb, ra - rb, ra < rb);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    sa = 3'($urandom);
                    sb = 3'($urandom);
                    sd = sa - sb;
                    op(3, 8'(sa), 8'(sb), 8'(sd), sa < sb);
                end
            end
        join

        repeat (5) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 0);
        check("q3_drained", 32'(q3.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
